word_fifo32: RTL
================

// Module: word_fifo32
// PURPOSE
//   Synchronous FIFO that buffers 32-bit words between a producer and a consumer in the emulator datapath.
//   Write side captures `in` on the rising edge of clk, like a 32-bit flipflop stage.
//   Read side pops the oldest word onto a registered `out` that holds until the next pop.
//   Decouples units running at different issue rates, e.g. an instruction prefetch queue or an I/O word buffer.
// PARAMETERS
//   WIDTH   32  data word width in bits
//   DEPTH   4   number of entries; must be a power of two, >= 2
//   AW      $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//   clk        input   1        rising-edge clock
//   reset_n    input   1        asynchronous, active-low reset
//   in         input   WIDTH    write data
//   wr_en      input   1        push request; sampled at posedge clk
//   rd_en      input   1        pop request; sampled at posedge clk
//   out        output  WIDTH    registered read data; holds value between pops
//   out_valid  output  1        1 for exactly the cycle after an accepted pop
//   full       output  1        count == DEPTH
//   empty      output  1        count == 0
//   count      output  AW+1     number of stored words, 0..DEPTH
//   overflow   output  1        sticky: a push was attempted while full and not popping
//   underflow  output  1        sticky: a pop was attempted while empty
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous, no clk edge required):
//     - Pointers and count go to 0; out=0, out_valid=0, overflow=0, underflow=0; full=0, empty=1.
//     - Storage array contents are don't-care.
//     - Reset asserted mid-operation discards all stored words immediately.
//   Storage and pointers:
//     - Circular buffer with wr_ptr and rd_ptr, each AW bits; both wrap DEPTH-1 -> 0 naturally.
//     - count is held as a separate register; full and empty decode combinationally from count.
//   Push acceptance at posedge clk:
//     - acc_wr = wr_en & (~full | acc_rd).
//     - On acc_wr: mem[wr_ptr] <= in; wr_ptr increments.
//   Pop acceptance at posedge clk:
//     - acc_rd = rd_en & ~empty.
//     - On acc_rd: out <= mem[rd_ptr]; rd_ptr increments; out_valid <= 1.
//     - Otherwise out_valid <= 0 and out holds its previous value.
//     - Read latency is 1 cycle from the sampling edge. There is no write-to-read bypass.
//   Count update:
//     - acc_wr & ~acc_rd: count+1.
//     - acc_rd & ~acc_wr: count-1.
//     - Both or neither: count unchanged.
//   Simultaneous events:
//     - Full, wr_en and rd_en together: the pop frees a slot and the push is accepted; count stays DEPTH.
//     - Empty, wr_en and rd_en together: the push is accepted and the pop is ignored.
//       underflow sets, count becomes 1, out unchanged, out_valid=0.
//   Error cases:
//     - wr_en while full with no accepted pop: data dropped, state unchanged, overflow <= 1.
//     - rd_en while empty: underflow <= 1.
//     - overflow and underflow clear only on reset.
//   Outputs: all are registered or decoded from registers only; no combinational path from inputs.
// TESTING
//   1. Reset: reset_n=0 with clk idle -> out=0, empty=1, full=0, count=0, flags=0 with no clk edge.
//   2. Push 32'h3655_4B68 then pop -> count 1 -> 0; out=32'h3655_4B68 and out_valid=1 one cycle after the pop edge.
//   3. Fill with 32'h0000_0001..32'h0000_0004 -> full=1.
//      Extra push of 32'hDEAD_BEEF -> overflow=1, count=4.
//      Then 4 pops -> out sequence 1,2,3,4; empty=1.
//   4. Full plus simultaneous push 32'hAC6D_2299 and pop -> out=32'h0000_0001, count stays 4.
//      Then 4 pops -> 2,3,4,32'hAC6D_2299.
//   5. Wrap: 10 interleaved push/pop pairs with values 0..9 -> out follows 0..9 in order, count never exceeds 1, flags stay 0.
//   6. Pop on empty -> underflow=1, out holds last value, out_valid=0.
//      Then assert reset_n=0 while count=3 -> count=0, empty=1, underflow=0 asynchronously.

Source files
------------

// File: rtl/word_fifo32.sv
// Synchronous word FIFO with registered read data, occupancy count and sticky
// overflow/underflow flags. Storage is not reset; only control state is.
module word_fifo32 #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             acc_wr, acc_rd;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign acc_rd = rd_en & ~empty;
  assign acc_wr = wr_en & (~full | acc_rd);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (acc_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (acc_rd) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_d       = mem[rd_ptr_q];
      out_valid_d = 1'b1;
    end

    if (acc_wr && !acc_rd) begin
      count_d = count_q + (AW+1)'(1);
    end else if (acc_rd && !acc_wr) begin
      count_d = count_q - (AW+1)'(1);
    end

    if (wr_en && full && !acc_rd) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      mem[wr_ptr_q] <= in;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
